// File: rtl/ofs_plat_avalon_mem_rd_credit.sv
`default_nettype none
// ============================================================================
// Module   : ofs_plat_avalon_mem_rd_credit
// Purpose  : Holds off Avalon-MM read bursts that would overrun the downstream
//            response buffer. Optional statistics: OFS_PLAT_AVALON_RD_CREDIT_STATS_EN
// Revision : 1.0  initial release
// ============================================================================
module ofs_plat_avalon_mem_rd_credit #(
  parameter int ADDR_WIDTH          = 32,
  parameter int DATA_WIDTH          = 512,
  parameter int BURST_CNT_WIDTH     = 7,
  parameter int MAX_ACTIVE_RD_BEATS = 256
) (
  input  logic                       clk,
  input  logic                       reset_n,

  input  logic                       src_read,
  input  logic                       src_write,
  input  logic [ADDR_WIDTH-1:0]      src_address,
  input  logic [BURST_CNT_WIDTH-1:0] src_burstcount,
  input  logic [DATA_WIDTH-1:0]      src_writedata,
  input  logic [DATA_WIDTH/8-1:0]    src_byteenable,
  output logic                       src_waitrequest,
  output logic [DATA_WIDTH-1:0]      src_readdata,
  output logic                       src_readdatavalid,
  output logic [1:0]                 src_response,

  output logic                       sink_read,
  output logic                       sink_write,
  output logic [ADDR_WIDTH-1:0]      sink_address,
  output logic [BURST_CNT_WIDTH-1:0] sink_burstcount,
  output logic [DATA_WIDTH-1:0]      sink_writedata,
  output logic [DATA_WIDTH/8-1:0]    sink_byteenable,
  input  logic                       sink_waitrequest,
  input  logic [DATA_WIDTH-1:0]      sink_readdata,
  input  logic                       sink_readdatavalid,
  input  logic [1:0]                 sink_response,

  output logic [31:0]                stall_cycles,
  output logic                       underflow_err
);

  localparam int c_cnt_w = $clog2(MAX_ACTIVE_RD_BEATS + 1);
  localparam logic [c_cnt_w:0] c_max_beats = (c_cnt_w + 1)'(MAX_ACTIVE_RD_BEATS);

  logic [c_cnt_w-1:0] r_active_beats;
  logic [c_cnt_w-1:0] w_active_next;
  logic [c_cnt_w:0]   w_credit_sum;
  logic               w_credit_ok;
  logic               w_rd_accept;

  // One bit wider than the counter so the sum cannot wrap.
  assign w_credit_sum = (c_cnt_w + 1)'(r_active_beats) + (c_cnt_w + 1)'(src_burstcount);
  assign w_credit_ok  = (w_credit_sum <= c_max_beats);

  assign sink_read       = src_read && w_credit_ok && reset_n;
  assign sink_write      = src_write && reset_n;
  assign sink_address    = src_address;
  assign sink_burstcount = src_burstcount;
  assign sink_writedata  = src_writedata;
  assign sink_byteenable = src_byteenable;
  assign src_waitrequest = sink_waitrequest || (src_read && !w_credit_ok) || !reset_n;

  assign src_readdata      = sink_readdata;
  assign src_readdatavalid = sink_readdatavalid;
  assign src_response      = sink_response;

  assign w_rd_accept = sink_read && !sink_waitrequest;

  // A beat returning with nothing outstanding is dropped rather than wrapping.
  always_comb begin
    w_active_next = r_active_beats;
    if (w_rd_accept)
      w_active_next = w_active_next + c_cnt_w'(src_burstcount);
    if (sink_readdatavalid && (r_active_beats != '0))
      w_active_next = w_active_next - c_cnt_w'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_active_beats <= '0;
    else
      r_active_beats <= w_active_next;
  end

`ifdef OFS_PLAT_AVALON_RD_CREDIT_STATS_EN
  logic [31:0] r_stall_cycles;
  logic        r_underflow_err;
  logic        w_underflow;

  assign w_underflow = sink_readdatavalid && (r_active_beats == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles  <= '0;
      r_underflow_err <= 1'b0;
    end else begin
      if (src_read && !w_credit_ok && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_underflow)
        r_underflow_err <= 1'b1;
    end
  end

  assign stall_cycles  = r_stall_cycles;
  assign underflow_err = r_underflow_err;
`else
  assign stall_cycles  = '0;
  assign underflow_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ofs_plat_avalon_mem_rd_credit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofs_plat_avalon_mem_rd_credit
// Purpose  : Self-checking bench for the read-credit limiter (MAX=16, BCW=5).
// Revision : 1.0  initial release
// ============================================================================
module tb_ofs_plat_avalon_mem_rd_credit;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int BCW = 5;
  localparam int MAX = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            src_read = 1'b0, src_write = 1'b0;
  logic [AW-1:0]   src_address = '0;
  logic [BCW-1:0]  src_burstcount = 5'd1;
  logic [DW-1:0]   src_writedata = '0;
  logic [DW/8-1:0] src_byteenable = '0;
  logic            src_waitrequest;
  logic [DW-1:0]   src_readdata;
  logic            src_readdatavalid;
  logic [1:0]      src_response;
  logic            sink_read, sink_write;
  logic [AW-1:0]   sink_address;
  logic [BCW-1:0]  sink_burstcount;
  logic [DW-1:0]   sink_writedata;
  logic [DW/8-1:0] sink_byteenable;
  logic            sink_waitrequest = 1'b0;
  logic [DW-1:0]   sink_readdata = '0;
  logic            sink_readdatavalid = 1'b0;
  logic [1:0]      sink_response = '0;
  logic [31:0]     stall_cycles;
  logic            underflow_err;

  always #5 clk = ~clk;

  ofs_plat_avalon_mem_rd_credit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BCW), .MAX_ACTIVE_RD_BEATS(MAX)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .src_read(src_read), .src_write(src_write), .src_address(src_address),
    .src_burstcount(src_burstcount), .src_writedata(src_writedata),
    .src_byteenable(src_byteenable), .src_waitrequest(src_waitrequest),
    .src_readdata(src_readdata), .src_readdatavalid(src_readdatavalid),
    .src_response(src_response),
    .sink_read(sink_read), .sink_write(sink_write), .sink_address(sink_address),
    .sink_burstcount(sink_burstcount), .sink_writedata(sink_writedata),
    .sink_byteenable(sink_byteenable), .sink_waitrequest(sink_waitrequest),
    .sink_readdata(sink_readdata), .sink_readdatavalid(sink_readdatavalid),
    .sink_response(sink_response),
    .stall_cycles(stall_cycles), .underflow_err(underflow_err)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  // Reference model: outstanding beats as a plain integer
  int     m_active = 0;
  longint m_stall  = 0;
  bit     m_uflow  = 1'b0;
  bit     held     = 1'b0;

  typedef struct {
    bit rd; bit wr; int bc; bit wq; bit rdv;
    bit e_sread; bit e_swrite; bit e_wait; int e_active;
  } vec_t;
  vec_t tbl [15];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint exp_stall();
`ifdef OFS_PLAT_AVALON_RD_CREDIT_STATS_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  function automatic longint exp_uflow();
`ifdef OFS_PLAT_AVALON_RD_CREDIT_STATS_EN
    return longint'(m_uflow);
`else
    return 0;
`endif
  endfunction

  task automatic drive(input bit rd, input bit wr, input int bc, input bit wq, input bit rdv);
    src_read           = rd;
    src_write          = wr;
    src_burstcount     = BCW'(bc);
    sink_waitrequest   = wq;
    sink_readdatavalid = rdv;
    sink_readdata      = $urandom;
    sink_response      = 2'($urandom_range(0, 3));
  endtask

  // Checks one cycle against the model; entered just after an active edge.
  task automatic step(input string tag);
    bit ok, acc, uf, exp_wait;
    #3;
    ok       = (m_active + int'(src_burstcount)) <= MAX;
    exp_wait = sink_waitrequest || (src_read && !ok);
    chk({tag, " sink_read"}, longint'(sink_read), longint'(src_read && ok));
    chk({tag, " sink_write"}, longint'(sink_write), longint'(src_write));
    chk({tag, " src_waitrequest"}, longint'(src_waitrequest), longint'(exp_wait));
    chk({tag, " address"}, longint'(sink_address), longint'(src_address));
    chk({tag, " writedata"}, longint'(sink_writedata), longint'(src_writedata));
    chk({tag, " readdata"}, longint'(src_readdata), longint'(sink_readdata));
    chk({tag, " rdvalid"}, longint'(src_readdatavalid), longint'(sink_readdatavalid));
    chk({tag, " response"}, longint'(src_response), longint'(sink_response));
    acc  = src_read && ok && !sink_waitrequest;
    uf   = sink_readdatavalid && (m_active == 0);
    held = (src_read || src_write) && exp_wait;
    @(posedge clk);
    m_active = m_active + (acc ? int'(src_burstcount) : 0) - ((sink_readdatavalid && !uf) ? 1 : 0);
    if (uf) m_uflow = 1'b1;
    if (src_read && !ok && m_stall < 64'hFFFF_FFFF) m_stall++;
    #1;
    chk({tag, " active_beats"}, longint'(dut.r_active_beats), longint'(m_active));
    chk({tag, " stall_cycles"}, longint'(stall_cycles), exp_stall());
    chk({tag, " underflow_err"}, longint'(underflow_err), exp_uflow());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint s0;
    //             rd wr bc wq rdv  sread swrite wait active
    tbl[0]  = '{1, 0, 16, 0, 0,   1, 0, 0, 16};
    tbl[1]  = '{1, 0,  1, 0, 0,   0, 0, 1, 16};
    tbl[2]  = '{1, 0,  1, 0, 1,   0, 0, 1, 15};
    tbl[3]  = '{1, 0,  1, 0, 0,   1, 0, 0, 16};
    tbl[4]  = '{0, 1,  4, 0, 0,   0, 1, 0, 16};
    tbl[5]  = '{0, 1,  4, 1, 0,   0, 1, 1, 16};
    tbl[6]  = '{0, 0,  1, 0, 1,   0, 0, 0, 15};
    tbl[7]  = '{0, 0,  1, 0, 1,   0, 0, 0, 14};
    tbl[8]  = '{0, 0,  1, 0, 1,   0, 0, 0, 13};
    tbl[9]  = '{0, 0,  1, 0, 1,   0, 0, 0, 12};
    tbl[10] = '{0, 0,  1, 0, 1,   0, 0, 0, 11};
    tbl[11] = '{0, 0,  1, 0, 1,   0, 0, 0, 10};
    tbl[12] = '{1, 0,  6, 0, 1,   1, 0, 0, 15};
    tbl[13] = '{1, 0,  2, 0, 1,   0, 0, 1, 14};
    tbl[14] = '{1, 0,  2, 0, 0,   1, 0, 0, 16};

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    chk("reset sink_read", longint'(sink_read), 0);
    chk("reset src_waitrequest", longint'(src_waitrequest), 1);
    chk("reset active_beats", longint'(dut.r_active_beats), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rd, tbl[i].wr, tbl[i].bc, tbl[i].wq, tbl[i].rdv);
      src_address   = AW'($urandom);
      src_writedata = $urandom;
      #2;
      chk($sformatf("tbl%0d sink_read", i), longint'(sink_read), longint'(tbl[i].e_sread));
      chk($sformatf("tbl%0d sink_write", i), longint'(sink_write), longint'(tbl[i].e_swrite));
      chk($sformatf("tbl%0d waitreq", i), longint'(src_waitrequest), longint'(tbl[i].e_wait));
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d active", i), longint'(dut.r_active_beats), longint'(tbl[i].e_active));
    end
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 0, 1);
      step("drain1");
    end
    chk("drain1 empty", longint'(dut.r_active_beats), 0);

    // Sink back-pressure with credit available: no credit consumed, no stall
    s0 = longint'(stall_cycles);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 4, 1, 0);
      step("wq_hold");
    end
    chk("wq_hold stall unchanged", longint'(stall_cycles), s0);
    drive(1, 0, 4, 0, 0);
    step("wq_release");
    chk("wq_release active", longint'(dut.r_active_beats), 4);

    // Credit stall for 7 cycles
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 16, 0, 0);
      step("credit_stall");
    end
`ifdef OFS_PLAT_AVALON_RD_CREDIT_STATS_EN
    chk("credit_stall count", longint'(stall_cycles) - s0, 7);
`else
    chk("credit_stall count", longint'(stall_cycles), 0);
`endif
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 1);
      step("drain2");
    end

    // Underflow: beat returns with nothing outstanding
    drive(0, 0, 1, 0, 1);
    step("underflow");
    chk("underflow active", longint'(dut.r_active_beats), 0);
    drive(0, 0, 1, 0, 0);
    step("underflow_idle");

    // Reset with 8 beats outstanding
    drive(1, 0, 8, 0, 0);
    step("pre_reset");
    drive(1, 0, 16, 0, 0);
    reset_n = 1'b0;
    #2;
    chk("mid_reset sink_read", longint'(sink_read), 0);
    chk("mid_reset waitreq", longint'(src_waitrequest), 1);
    chk("mid_reset active", longint'(dut.r_active_beats), 0);
    chk("mid_reset stall", longint'(stall_cycles), 0);
    chk("mid_reset underflow", longint'(underflow_err), 0);
    m_active = 0; m_stall = 0; m_uflow = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    step("post_reset_b16");
    chk("post_reset active", longint'(dut.r_active_beats), 16);

    // Randomized traffic against the model
    held = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!held) begin
        src_read       = $urandom_range(0, 1) == 1;
        src_write      = !src_read && ($urandom_range(0, 2) == 0);
        src_burstcount = BCW'($urandom_range(1, 16));
        src_address    = AW'($urandom);
        src_writedata  = $urandom;
        src_byteenable = 4'($urandom);
      end
      sink_waitrequest   = $urandom_range(0, 3) == 0;
      sink_readdatavalid = (m_active > 0) && ($urandom_range(0, 1) == 1);
      sink_readdata      = $urandom;
      sink_response      = 2'($urandom_range(0, 3));
      step("rand");
    end
    for (int i = 0; i < 40 && m_active > 0; i++) begin
      drive(0, 0, 1, 0, 1);
      step("drain3");
    end
    chk("final empty", longint'(dut.r_active_beats), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
